// File: rtl/raytracing_scheduler.sv
// Line-by-line frame scheduler for a bank of ray-tracing workers.
// For each line it launches every worker, waits for all of them to finish,
// then drains the worker buffers into the framebuffer in pixel order.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   frame_start         start-frame request (only honoured in IDLE)
//   frame_busy          frame in progress
//   frame_done          one-cycle pulse after the last pixel of the frame
//   worker_activate     shared activate to all workers
//   worker_busy         per-worker busy flags
//   pixel_start_x       leftmost pixel X (constant)
//   pixel_y             current line Y (LINES/2 - line)
//   pixel_y_sqrd        pixel_y squared
//   rd_worker, rd_job   worker buffer select for readout
//   rd_color            selected buffer entry (external mux)
//   fb_we, fb_ready     framebuffer write handshake
//   fb_addr, fb_data    framebuffer address and pixel color
module raytracing_scheduler #(
    parameter int unsigned N_WORKERS        = 10,
    parameter int unsigned JOBS_SUBDIVISION = 64,
    parameter int unsigned COLS             = 640,
    parameter int unsigned LINES            = 480,
    localparam int unsigned WW = $clog2(N_WORKERS),
    localparam int unsigned JW = $clog2(JOBS_SUBDIVISION),
    localparam int unsigned AW = $clog2(COLS * LINES)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 frame_start,
    output logic                 frame_busy,
    output logic                 frame_done,
    output logic                 worker_activate,
    input  logic [N_WORKERS-1:0] worker_busy,
    output logic signed [11:0]   pixel_start_x,
    output logic signed [9:0]    pixel_y,
    output logic [15:0]          pixel_y_sqrd,
    output logic [WW-1:0]        rd_worker,
    output logic [JW-1:0]        rd_job,
    input  logic [11:0]          rd_color,
    output logic                 fb_we,
    input  logic                 fb_ready,
    output logic [AW-1:0]        fb_addr,
    output logic [11:0]          fb_data
);

    localparam int unsigned XW = $clog2(COLS);
    localparam int unsigned LW = $clog2(LINES);
    localparam logic signed [9:0] PY_TOP = 10'(LINES / 2);
    localparam logic [15:0]       SQ_TOP = 16'((LINES / 2) * (LINES / 2));

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LAUNCH = 3'd1,
        S_RUN    = 3'd2,
        S_DRAIN  = 3'd3,
        S_GAP    = 3'd4
    } state_e;

    state_e             state_q, state_d;
    logic [LW-1:0]      line_q, line_d;
    logic [XW-1:0]      x_q, x_d;
    logic [WW-1:0]      rd_worker_q, rd_worker_d;
    logic [JW-1:0]      rd_job_q, rd_job_d;
    logic [AW-1:0]      fb_addr_q, fb_addr_d;
    logic signed [9:0]  pixel_y_q, pixel_y_d;
    logic [15:0]        pixel_y_sqrd_q, pixel_y_sqrd_d;
    logic               frame_done_q, frame_done_d;
    logic               worker_activate_q, worker_activate_d;
    logic               frame_busy_q, frame_busy_d;
    logic               fb_we_q, fb_we_d;

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q           <= S_IDLE;
            line_q            <= '0;
            x_q               <= '0;
            rd_worker_q       <= '0;
            rd_job_q          <= '0;
            fb_addr_q         <= '0;
            pixel_y_q         <= PY_TOP;
            pixel_y_sqrd_q    <= SQ_TOP;
            frame_done_q      <= 1'b0;
            worker_activate_q <= 1'b0;
            frame_busy_q      <= 1'b0;
            fb_we_q           <= 1'b0;
        end else begin
            state_q           <= state_d;
            line_q            <= line_d;
            x_q               <= x_d;
            rd_worker_q       <= rd_worker_d;
            rd_job_q          <= rd_job_d;
            fb_addr_q         <= fb_addr_d;
            pixel_y_q         <= pixel_y_d;
            pixel_y_sqrd_q    <= pixel_y_sqrd_d;
            frame_done_q      <= frame_done_d;
            worker_activate_q <= worker_activate_d;
            frame_busy_q      <= frame_busy_d;
            fb_we_q           <= fb_we_d;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d        = state_q;
        line_d         = line_q;
        x_d            = x_q;
        rd_worker_d    = rd_worker_q;
        rd_job_d       = rd_job_q;
        fb_addr_d      = fb_addr_q;
        pixel_y_d      = pixel_y_q;
        pixel_y_sqrd_d = pixel_y_sqrd_q;
        frame_done_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (frame_start) begin
                    state_d        = S_LAUNCH;
                    line_d         = '0;
                    x_d            = '0;
                    rd_worker_d    = '0;
                    rd_job_d       = '0;
                    fb_addr_d      = '0;
                    pixel_y_d      = PY_TOP;
                    pixel_y_sqrd_d = SQ_TOP;
                end
            end
            S_LAUNCH: begin
                // Only a full set of busy flags proves every worker took the job
                if (&worker_busy) state_d = S_RUN;
            end
            S_RUN: begin
                if (~|worker_busy) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (fb_ready) begin
                    // Address runs across lines, so it equals line*COLS + x
                    fb_addr_d = fb_addr_q + AW'(1);
                    if (x_q == XW'(COLS - 1)) begin
                        x_d         = '0;
                        rd_worker_d = '0;
                        rd_job_d    = '0;
                        state_d     = S_GAP;
                    end else begin
                        x_d = x_q + XW'(1);
                        if (rd_worker_q == WW'(N_WORKERS - 1)) begin
                            rd_worker_d = '0;
                            rd_job_d    = rd_job_q + JW'(1);
                        end else begin
                            rd_worker_d = rd_worker_q + WW'(1);
                        end
                    end
                end
            end
            S_GAP: begin
                if (line_q == LW'(LINES - 1)) begin
                    frame_done_d = 1'b1;
                    state_d      = S_IDLE;
                end else begin
                    line_d    = line_q + LW'(1);
                    pixel_y_d = pixel_y_q - 10'sd1;
                    // (y-1)^2 = y^2 - 2y + 1, evaluated modulo 2^16
                    pixel_y_sqrd_d = pixel_y_sqrd_q
                                   - {{5{pixel_y_q[9]}}, pixel_y_q, 1'b0}
                                   + 16'd1;
                    state_d   = S_LAUNCH;
                end
            end
            default: state_d = S_IDLE;
        endcase

        worker_activate_d = (state_d == S_LAUNCH) || (state_d == S_RUN) ||
                            (state_d == S_DRAIN);
        frame_busy_d      = (state_d != S_IDLE);
        fb_we_d           = (state_d == S_DRAIN);
    end

    assign frame_busy      = frame_busy_q;
    assign frame_done      = frame_done_q;
    assign worker_activate = worker_activate_q;
    assign pixel_start_x   = 12'(0) - 12'(COLS / 2);
    assign pixel_y         = pixel_y_q;
    assign pixel_y_sqrd    = pixel_y_sqrd_q;
    assign rd_worker       = rd_worker_q;
    assign rd_job          = rd_job_q;
    assign fb_we           = fb_we_q;
    assign fb_addr         = fb_addr_q;
    assign fb_data         = rd_color;

endmodule

// File: tb/tb_raytracing_scheduler.sv
module tb_raytracing_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    int          total = 0;
    int          bad   = 0;

    always #5 clk = ~clk;

    // Full-size instance
    logic        frame_start, frame_busy, frame_done, worker_activate;
    logic [9:0]  worker_busy;
    logic signed [11:0] pixel_start_x;
    logic signed [9:0]  pixel_y;
    logic [15:0] pixel_y_sqrd;
    logic [3:0]  rd_worker;
    logic [5:0]  rd_job;
    logic [11:0] rd_color, fb_data;
    logic        fb_we, fb_ready;
    logic [18:0] fb_addr;

    assign rd_color = {2'b00, rd_worker, rd_job};

    raytracing_scheduler u_dut (
        .clk(clk), .rst(rst), .frame_start(frame_start), .frame_busy(frame_busy),
        .frame_done(frame_done), .worker_activate(worker_activate),
        .worker_busy(worker_busy), .pixel_start_x(pixel_start_x), .pixel_y(pixel_y),
        .pixel_y_sqrd(pixel_y_sqrd), .rd_worker(rd_worker), .rd_job(rd_job),
        .rd_color(rd_color), .fb_we(fb_we), .fb_ready(fb_ready), .fb_addr(fb_addr),
        .fb_data(fb_data)
    );

    // Narrow instance so a whole 480-line frame stays short
    logic        frame_start_s, frame_busy_s, frame_done_s, worker_activate_s;
    logic [1:0]  worker_busy_s;
    logic signed [11:0] pixel_start_x_s;
    logic signed [9:0]  pixel_y_s;
    logic [15:0] pixel_y_sqrd_s;
    logic [0:0]  rd_worker_s;
    logic [1:0]  rd_job_s;
    logic [11:0] rd_color_s, fb_data_s;
    logic        fb_we_s, fb_ready_s;
    logic [11:0] fb_addr_s;

    assign rd_color_s = {9'd0, rd_worker_s, rd_job_s};

    raytracing_scheduler #(.N_WORKERS(2), .JOBS_SUBDIVISION(4), .COLS(8), .LINES(480)) u_dut_s (
        .clk(clk), .rst(rst), .frame_start(frame_start_s), .frame_busy(frame_busy_s),
        .frame_done(frame_done_s), .worker_activate(worker_activate_s),
        .worker_busy(worker_busy_s), .pixel_start_x(pixel_start_x_s), .pixel_y(pixel_y_s),
        .pixel_y_sqrd(pixel_y_sqrd_s), .rd_worker(rd_worker_s), .rd_job(rd_job_s),
        .rd_color(rd_color_s), .fb_we(fb_we_s), .fb_ready(fb_ready_s), .fb_addr(fb_addr_s),
        .fb_data(fb_data_s)
    );

    // Worker models: worker 0 blips high once before the group really starts
    int busy_len = 8;
    int wcnt = 0;
    int wcnt_s = 0;
    initial begin
        worker_busy = '0;
        forever begin
            @(posedge clk); #1;
            if (!worker_activate) begin
                wcnt = 0;
                worker_busy = '0;
            end else begin
                wcnt++;
                for (int k = 0; k < 10; k++)
                    worker_busy[k] = ((k == 0) && (wcnt == 1)) ||
                                     ((wcnt >= 3 + k % 3) && (wcnt < busy_len + k % 4));
            end
        end
    end

    initial begin
        worker_busy_s = '0;
        forever begin
            @(posedge clk); #1;
            if (!worker_activate_s) begin
                wcnt_s = 0;
                worker_busy_s = '0;
            end else begin
                wcnt_s++;
                worker_busy_s = (wcnt_s >= 2 && wcnt_s < 4) ? 2'b11 : 2'b00;
            end
        end
    end

    // Scoreboard for the full-size instance
    typedef struct packed {
        logic [18:0] addr;
        logic [11:0] data;
    } exp_t;
    exp_t sb_q[$];
    exp_t mon_e;

    task automatic push_line(input int ln);
        exp_t e;
        for (int x = 0; x < 640; x++) begin
            e.addr = 19'(ln * 640 + x);
            e.data = 12'((x % 10) * 64 + x / 10);
            sb_q.push_back(e);
        end
    endtask

    always @(negedge clk) begin
        if (fb_we && fb_ready) begin
            total++;
            if (sb_q.size() == 0) begin
                bad++;
                $display("FAIL sb_underflow: unexpected write addr=%0d data=%h", fb_addr, fb_data);
            end else begin
                mon_e = sb_q.pop_front();
                if (fb_addr !== mon_e.addr || fb_data !== mon_e.data) begin
                    bad++;
                    $display("FAIL sb_write: got addr=%0d data=%h expected addr=%0d data=%h",
                             fb_addr, fb_data, mon_e.addr, mon_e.data);
                end
            end
        end
    end

    task automatic start_frame();
        @(posedge clk); #1 frame_start = 1'b1;
        @(posedge clk); #1 frame_start = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        sb_q.delete();
    endtask

    task automatic test_reset();
        logic signed [11:0] exp_sx;
        exp_sx = -12'sd320;
        rst = 1'b1;
        frame_start = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total += 12;
        if (frame_busy !== 1'b0)      begin bad++; $display("FAIL rst_busy got=%b exp=0", frame_busy); end
        if (frame_done !== 1'b0)      begin bad++; $display("FAIL rst_done got=%b exp=0", frame_done); end
        if (worker_activate !== 1'b0) begin bad++; $display("FAIL rst_act got=%b exp=0", worker_activate); end
        if (fb_we !== 1'b0)           begin bad++; $display("FAIL rst_we got=%b exp=0", fb_we); end
        if (pixel_y !== 10'sd240)     begin bad++; $display("FAIL rst_py got=%0d exp=240", pixel_y); end
        if (pixel_y_sqrd !== 16'd57600) begin bad++; $display("FAIL rst_sq got=%0d exp=57600", pixel_y_sqrd); end
        if (rd_worker !== 4'd0)       begin bad++; $display("FAIL rst_rdw got=%0d exp=0", rd_worker); end
        if (rd_job !== 6'd0)          begin bad++; $display("FAIL rst_rdj got=%0d exp=0", rd_job); end
        if (fb_addr !== 19'd0)        begin bad++; $display("FAIL rst_addr got=%0d exp=0", fb_addr); end
        if (pixel_start_x !== exp_sx) begin bad++; $display("FAIL start_x got=%0d exp=-320", pixel_start_x); end
        if (fb_data !== 12'd0)        begin bad++; $display("FAIL rst_data got=%h exp=0", fb_data); end
        if (frame_busy_s !== 1'b0)    begin bad++; $display("FAIL rst_busy_s got=%b exp=0", frame_busy_s); end
        @(posedge clk); #1;
        frame_start = 1'b0;
        rst = 1'b0;
    endtask

    task automatic test_single_line();
        int cyc, first_we, we_cnt;
        bit seen, done;
        busy_len = 100;
        fb_ready = 1'b1;
        push_line(0);
        start_frame();
        cyc = 0; first_we = -1; we_cnt = 0; seen = 0; done = 0;
        for (int i = 0; i < 3000 && !done; i++) begin
            @(negedge clk);
            cyc++;
            if (fb_we) begin
                if (!seen) begin
                    seen = 1; first_we = cyc;
                    total += 2;
                    if (pixel_y !== 10'sd240) begin bad++; $display("FAIL line0_py got=%0d exp=240", pixel_y); end
                    if (pixel_y_sqrd !== 16'd57600) begin bad++; $display("FAIL line0_sq got=%0d exp=57600", pixel_y_sqrd); end
                end
                if (fb_ready) we_cnt++;
                if (fb_addr == 19'd23) begin
                    total++;
                    if (fb_data !== 12'd194) begin bad++; $display("FAIL map_23 got=%h exp=%h", fb_data, 12'd194); end
                end
                if (fb_addr == 19'd639) begin
                    total++;
                    if (fb_data !== 12'd639) begin bad++; $display("FAIL map_639 got=%h exp=%h", fb_data, 12'd639); end
                end
            end else if (seen) begin
                done = 1;
                total += 2;
                if (worker_activate !== 1'b0) begin bad++; $display("FAIL gap_act got=%b exp=0", worker_activate); end
                if (frame_busy !== 1'b1) begin bad++; $display("FAIL gap_busy got=%b exp=1", frame_busy); end
            end
        end
        total += 3;
        if (!done) begin bad++; $display("FAIL line_timeout got=no_gap exp=gap"); end
        if (we_cnt != 640) begin bad++; $display("FAIL we_count got=%0d exp=640", we_cnt); end
        if (first_we < 100) begin bad++; $display("FAIL drain_early got=%0d exp>=100", first_we); end
        @(negedge clk);
        total += 4;
        if (worker_activate !== 1'b1) begin bad++; $display("FAIL relaunch_act got=%b exp=1", worker_activate); end
        if (pixel_y !== 10'sd239) begin bad++; $display("FAIL line1_py got=%0d exp=239", pixel_y); end
        if (pixel_y_sqrd !== 16'd57121) begin bad++; $display("FAIL line1_sq got=%0d exp=57121", pixel_y_sqrd); end
        if (sb_q.size() != 0) begin bad++; $display("FAIL sb_left got=%0d exp=0", sb_q.size()); end
        do_reset();
    endtask

    task automatic test_stall();
        int acc;
        bit seen, done, held;
        logic [18:0] h_addr;
        logic [11:0] h_data;
        busy_len = 8;
        fb_ready = 1'b1;
        push_line(0);
        start_frame();
        acc = 0; seen = 0; done = 0; held = 0; h_addr = '0; h_data = '0;
        for (int i = 0; i < 4000 && !done; i++) begin
            @(posedge clk); #1;
            fb_ready = ~fb_ready;
            @(negedge clk);
            if (fb_we) begin
                seen = 1;
                if (held) begin
                    held = 0;
                    total++;
                    if (fb_addr !== h_addr || fb_data !== h_data) begin
                        bad++;
                        $display("FAIL stall_hold got addr=%0d data=%h exp addr=%0d data=%h",
                                 fb_addr, fb_data, h_addr, h_data);
                    end
                end
                if (!fb_ready) begin
                    held = 1; h_addr = fb_addr; h_data = fb_data;
                end else begin
                    acc++;
                end
            end else if (seen) begin
                done = 1;
            end
        end
        total += 3;
        if (!done) begin bad++; $display("FAIL stall_timeout got=no_end exp=end"); end
        if (acc != 640) begin bad++; $display("FAIL stall_accepts got=%0d exp=640", acc); end
        if (sb_q.size() != 0) begin bad++; $display("FAIL stall_sb_left got=%0d exp=0", sb_q.size()); end
        fb_ready = 1'b1;
        do_reset();
    endtask

    task automatic test_midframe_reset();
        int cur, ones, rst_stage;
        bit prev_act, pulsed, req_fs, done, saw_we;
        busy_len = 8;
        fb_ready = 1'b1;
        start_frame();
        cur = 0; ones = 0; rst_stage = 0; prev_act = 0; pulsed = 0; req_fs = 0; done = 0;
        for (int i = 0; i < 8000 && !done; i++) begin
            @(posedge clk); #1;
            frame_start = req_fs;
            req_fs = 0;
            if (rst_stage == 1) begin rst = 1'b1; rst_stage = 2; end
            else if (rst_stage == 2) begin rst = 1'b0; rst_stage = 3; end
            @(negedge clk);
            if (rst_stage == 3) begin
                done = 1;
                total += 7;
                if (worker_activate !== 1'b0) begin bad++; $display("FAIL mrst_act got=%b exp=0", worker_activate); end
                if (frame_busy !== 1'b0) begin bad++; $display("FAIL mrst_busy got=%b exp=0", frame_busy); end
                if (pixel_y !== 10'sd240) begin bad++; $display("FAIL mrst_py got=%0d exp=240", pixel_y); end
                if (fb_addr !== 19'd0) begin bad++; $display("FAIL mrst_addr got=%0d exp=0", fb_addr); end
                if (rd_worker !== 4'd0 || rd_job !== 6'd0) begin bad++; $display("FAIL mrst_rd got=%0d/%0d exp=0/0", rd_worker, rd_job); end
                if (fb_we !== 1'b0) begin bad++; $display("FAIL mrst_we got=%b exp=0", fb_we); end
                if (sb_q.size() != 640) begin bad++; $display("FAIL mrst_writes got_left=%0d exp_left=640", sb_q.size()); end
            end else begin
                if (worker_activate && !prev_act) begin
                    total += 2;
                    if (pixel_y !== 10'(240 - cur)) begin bad++; $display("FAIL ml_py line=%0d got=%0d exp=%0d", cur, pixel_y, 240 - cur); end
                    if (pixel_y_sqrd !== 16'((240 - cur) * (240 - cur))) begin bad++; $display("FAIL ml_sq line=%0d got=%0d exp=%0d", cur, pixel_y_sqrd, (240 - cur) * (240 - cur)); end
                    push_line(cur);
                    cur++;
                end
                prev_act = worker_activate;
                ones = (worker_activate && (&worker_busy)) ? ones + 1 : 0;
                if (ones == 2 && cur == 2 && !pulsed) begin req_fs = 1; pulsed = 1; end
                if (ones == 2 && cur == 6 && rst_stage == 0) rst_stage = 1;
            end
        end
        total++;
        if (!done) begin bad++; $display("FAIL mrst_timeout got=line%0d exp=line5", cur); end
        sb_q.delete();
        saw_we = 0;
        repeat (150) begin
            @(negedge clk);
            if (fb_we || frame_busy) saw_we = 1;
        end
        total++;
        if (saw_we) begin bad++; $display("FAIL post_rst_activity got=1 exp=0"); end
        start_frame();
        @(negedge clk);
        total++;
        if (worker_activate !== 1'b1 || frame_busy !== 1'b1) begin
            bad++; $display("FAIL restart got act=%b busy=%b exp act=1 busy=1", worker_activate, frame_busy);
        end
        do_reset();
    endtask

    task automatic test_full_frame();
        int ln, exp_addr, last_addr, pulses, x;
        bit prev_act, done;
        fb_ready_s = 1'b1;
        ln = 0; exp_addr = 0; last_addr = -1; pulses = 0; prev_act = 0; done = 0;
        @(posedge clk); #1 frame_start_s = 1'b1;
        for (int i = 0; i < 12000 && !done; i++) begin
            @(negedge clk);
            if (worker_activate_s && !prev_act) begin
                total += 2;
                if (pixel_y_s !== 10'(240 - ln)) begin bad++; $display("FAIL ff_py line=%0d got=%0d exp=%0d", ln, pixel_y_s, 240 - ln); end
                if (pixel_y_sqrd_s !== 16'((240 - ln) * (240 - ln))) begin bad++; $display("FAIL ff_sq line=%0d got=%0d exp=%0d", ln, pixel_y_sqrd_s, (240 - ln) * (240 - ln)); end
                ln++;
            end
            prev_act = worker_activate_s;
            if (fb_we_s && fb_ready_s) begin
                x = exp_addr % 8;
                total += 2;
                if (fb_addr_s !== 12'(exp_addr)) begin bad++; $display("FAIL ff_addr got=%0d exp=%0d", fb_addr_s, exp_addr); end
                if (fb_data_s !== 12'((x % 2) * 4 + x / 2)) begin bad++; $display("FAIL ff_data addr=%0d got=%h exp=%h", exp_addr, fb_data_s, 12'((x % 2) * 4 + x / 2)); end
                last_addr = int'(fb_addr_s);
                exp_addr++;
            end
            if (frame_done_s) begin
                pulses++;
                done = 1;
                total++;
                if (frame_busy_s !== 1'b0) begin bad++; $display("FAIL ff_done_busy got=%b exp=0", frame_busy_s); end
            end
        end
        total += 4;
        if (!done) begin bad++; $display("FAIL ff_timeout got=no_done exp=done"); end
        if (ln != 480) begin bad++; $display("FAIL ff_lines got=%0d exp=480", ln); end
        if (last_addr != 3839) begin bad++; $display("FAIL ff_last_addr got=%0d exp=3839", last_addr); end
        if (pulses != 1) begin bad++; $display("FAIL ff_pulses got=%0d exp=1", pulses); end
        @(negedge clk);
        total++;
        if (frame_busy_s !== 1'b1 || worker_activate_s !== 1'b1 || frame_done_s !== 1'b0) begin
            bad++; $display("FAIL ff_held_start got busy=%b act=%b done=%b exp 1/1/0",
                            frame_busy_s, worker_activate_s, frame_done_s);
        end
        @(posedge clk); #1 frame_start_s = 1'b0;
        do_reset();
    endtask

    initial begin
        rst = 1'b1;
        frame_start = 1'b0;
        frame_start_s = 1'b0;
        fb_ready = 1'b1;
        fb_ready_s = 1'b1;
        test_reset();
        test_single_line();
        test_stall();
        test_midframe_reset();
        test_full_frame();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
